// File: rtl/mem_stage_ctrl_pkg.sv
// Shared memory-stage definitions: widths, FSM encoding, request payload.
package mem_stage_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0800;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// EX/MEM request, MEM/WB result and data-memory handshake bundle.
interface mem_stage_ctrl_if;
    import mem_stage_ctrl_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_dump;
    logic              req_halt;
    logic              pipe_stall;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_dump;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;
    logic              mem_done;
    logic              mem_err;
    logic              err;
    logic              halted;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_dump, req_halt,
        input  mem_rdata, mem_stall, mem_done, mem_err,
        output pipe_stall, rdata, rdata_valid,
        output mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump,
        output err, halted
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_dump, req_halt,
        output mem_rdata, mem_stall, mem_done, mem_err,
        input  pipe_stall, rdata, rdata_valid,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump,
        input  err, halted
    );

endinterface

// File: rtl/mem_stage_ctrl_req_latch.sv
// Holds the accepted request stable for the whole memory access.
module mem_req_latch
    import mem_stage_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  mem_req_t d,
    output mem_req_t q
);

    // Capture a new request only when the controller accepts one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: runs EX/MEM requests against a stallable memory.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_stage_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              halted_q, halted_d;
    logic              req_load;
    mem_req_t          req_d, req_q;
    logic              stall_c, rd_c, wr_c, dump_c, rvalid_c;

    assign req_d = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

    mem_req_latch u_req_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (req_load),
        .d     (req_d),
        .q     (req_q)
    );

    // State and status registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            halted_q <= halted_d;
        end
    end

    // Next-state, strobe and stall decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        halted_d = halted_q;
        req_load = 1'b0;
        stall_c  = 1'b0;
        rd_c     = 1'b0;
        wr_c     = 1'b0;
        dump_c   = 1'b0;
        rvalid_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && !halted_q) begin
                    stall_c  = 1'b1;
                    req_load = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    dump_c = bus.req_dump;
                    if (bus.req_halt) begin
                        halted_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                stall_c = 1'b1;
                rd_c    = ~req_q.write;
                wr_c    = req_q.write;
                if (bus.mem_err) begin
                    err_d = 1'b1;
                end
                if (!bus.mem_stall) begin
                    if (bus.mem_done) begin
                        if (!req_q.write) begin
                            rdata_d = bus.mem_rdata;
                        end
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (bus.mem_err) begin
                    err_d = 1'b1;
                end
                // Completion beats a timeout landing in the same cycle.
                if (bus.mem_done) begin
                    if (!req_q.write) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                rvalid_c = ~req_q.write;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // IDLE-cycle outputs follow inputs, so mask them while reset is held.
    assign bus.pipe_stall  = stall_c & rst_n;
    assign bus.mem_dump    = dump_c & rst_n;
    assign bus.mem_rd      = rd_c;
    assign bus.mem_wr      = wr_c;
    assign bus.mem_addr    = req_q.addr;
    assign bus.mem_wdata   = req_q.wdata;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_c;
    assign bus.err         = err_q;
    assign bus.halted      = halted_q;

endmodule
